// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: mnemonic codes, opcode/funct fields and encoder helpers.
// Also used by the instruction decoder.
package rv32i_pkg;

    typedef enum logic [5:0] {
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd,
        OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi, OpSlli, OpSrli, OpSrai,
        OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
        OpJal, OpJalr, OpLui, OpAuipc
    } op_e;

    typedef enum logic [3:0] {
        FmtBad, FmtR, FmtI, FmtShift, FmtS, FmtB, FmtJ, FmtU
    } fmt_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam logic [31:0] ErrNop = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } fifo_entry_t;

    // True when v is representable as a signed value of (msb+1) bits.
    function automatic logic fits_simm(input logic [31:0] v, input int unsigned msb);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> msb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/inst_enc_core.sv
// Combinational RV32I encoder: mnemonic plus operands to a 32-bit word and an
// illegal flag for unknown ops or out-of-range immediates.
module inst_enc_core
    import rv32i_pkg::*;
(
    input  op_e         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    always_comb begin
        fmt = FmtBad;
        opc = OpcOp;
        f3  = 3'd0;
        f7  = F7Base;
        case (op)
            OpAdd:   begin fmt = FmtR; f3 = 3'd0; end
            OpSub:   begin fmt = FmtR; f3 = 3'd0; f7 = F7Alt; end
            OpSll:   begin fmt = FmtR; f3 = 3'd1; end
            OpSlt:   begin fmt = FmtR; f3 = 3'd2; end
            OpSltu:  begin fmt = FmtR; f3 = 3'd3; end
            OpXor:   begin fmt = FmtR; f3 = 3'd4; end
            OpSrl:   begin fmt = FmtR; f3 = 3'd5; end
            OpSra:   begin fmt = FmtR; f3 = 3'd5; f7 = F7Alt; end
            OpOr:    begin fmt = FmtR; f3 = 3'd6; end
            OpAnd:   begin fmt = FmtR; f3 = 3'd7; end
            OpAddi:  begin fmt = FmtI; opc = OpcOpImm; f3 = 3'd0; end
            OpSlti:  begin fmt = FmtI; opc = OpcOpImm; f3 = 3'd2; end
            OpSltiu: begin fmt = FmtI; opc = OpcOpImm; f3 = 3'd3; end
            OpXori:  begin fmt = FmtI; opc = OpcOpImm; f3 = 3'd4; end
            OpOri:   begin fmt = FmtI; opc = OpcOpImm; f3 = 3'd6; end
            OpAndi:  begin fmt = FmtI; opc = OpcOpImm; f3 = 3'd7; end
            OpSlli:  begin fmt = FmtShift; opc = OpcOpImm; f3 = 3'd1; end
            OpSrli:  begin fmt = FmtShift; opc = OpcOpImm; f3 = 3'd5; end
            OpSrai:  begin fmt = FmtShift; opc = OpcOpImm; f3 = 3'd5; f7 = F7Alt; end
            OpLb:    begin fmt = FmtI; opc = OpcLoad; f3 = 3'd0; end
            OpLh:    begin fmt = FmtI; opc = OpcLoad; f3 = 3'd1; end
            OpLw:    begin fmt = FmtI; opc = OpcLoad; f3 = 3'd2; end
            OpLbu:   begin fmt = FmtI; opc = OpcLoad; f3 = 3'd4; end
            OpLhu:   begin fmt = FmtI; opc = OpcLoad; f3 = 3'd5; end
            OpSb:    begin fmt = FmtS; opc = OpcStore; f3 = 3'd0; end
            OpSh:    begin fmt = FmtS; opc = OpcStore; f3 = 3'd1; end
            OpSw:    begin fmt = FmtS; opc = OpcStore; f3 = 3'd2; end
            OpBeq:   begin fmt = FmtB; opc = OpcBranch; f3 = 3'd0; end
            OpBne:   begin fmt = FmtB; opc = OpcBranch; f3 = 3'd1; end
            OpBlt:   begin fmt = FmtB; opc = OpcBranch; f3 = 3'd4; end
            OpBge:   begin fmt = FmtB; opc = OpcBranch; f3 = 3'd5; end
            OpBltu:  begin fmt = FmtB; opc = OpcBranch; f3 = 3'd6; end
            OpBgeu:  begin fmt = FmtB; opc = OpcBranch; f3 = 3'd7; end
            OpJal:   begin fmt = FmtJ; opc = OpcJal; end
            OpJalr:  begin fmt = FmtI; opc = OpcJalr; f3 = 3'd0; end
            OpLui:   begin fmt = FmtU; opc = OpcLui; end
            OpAuipc: begin fmt = FmtU; opc = OpcAuipc; end
            default: fmt = FmtBad;
        endcase
    end

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FmtR: word = {f7, rs2, rs1, f3, rd, opc};
            FmtI: begin
                word    = {imm[11:0], rs1, f3, rd, opc};
                illegal = !fits_simm(imm, 11);
            end
            FmtShift: begin
                word    = {f7, imm[4:0], rs1, f3, rd, opc};
                illegal = (imm[31:5] != '0);
            end
            FmtS: begin
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                illegal = !fits_simm(imm, 11);
            end
            FmtB: begin
                word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                illegal = !fits_simm(imm, 12) || imm[0];
            end
            FmtJ: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                illegal = !fits_simm(imm, 20) || imm[0];
            end
            FmtU: begin
                word    = {imm[31:12], rd, opc};
                illegal = (imm[11:0] != '0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Registered RV32I encoder: ready/valid request in, 2-entry output FIFO of
// {word, address, error} out, with an address counter and illegal-request count.
module inst_encoder
    import rv32i_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ERR_NOP   = ErrNop
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  op_e         in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    fifo_entry_t mem_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic [31:0] addr_q;
    logic [7:0]  err_cnt_q;

    logic [31:0] enc_word;
    logic        enc_illegal;
    fifo_entry_t new_entry;
    logic        push, pop;

    inst_enc_core u_core (
        .op      (in_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // Ready is gated by reset so it stays low while reset is held.
    assign in_ready  = reset && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_inst  = mem_q[rd_ptr_q].inst;
    assign out_addr  = mem_q[rd_ptr_q].addr;
    assign out_err   = mem_q[rd_ptr_q].err;
    assign err_count = err_cnt_q;

    always_comb begin
        new_entry.inst = enc_illegal ? ERR_NOP : enc_word;
        new_entry.addr = addr_q;
        new_entry.err  = enc_illegal;
        count_d        = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            addr_q    <= BASE_ADDR;
            err_cnt_q <= 8'd0;
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= ~wr_ptr_q;
                addr_q          <= addr_q + 32'd4;
                if (enc_illegal && (err_cnt_q != 8'hFF)) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed encoding table plus
// back-to-back, backpressure, address-wrap and mid-stream reset sequences.
module tb_inst_encoder;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    op_e         in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        out_ready;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst, out_addr;
    logic [7:0]  err_count;
    logic        w_in_ready, w_out_valid, w_out_err;
    logic [31:0] w_out_inst, w_out_addr;
    logic [7:0]  w_err_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_addr;
    logic [7:0]  exp_errs;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    inst_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_inst(w_out_inst),
        .out_addr(w_out_addr), .out_err(w_out_err), .err_count(w_err_count)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        in_valid = 1'b1;
        in_op    = op_e'(op);
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{6'(OpAddi),  5'd1, 5'd0, 5'd7, 32'd5,          32'h0050_0093, 1'b0};
        vecs[1]  = '{6'(OpBeq),   5'd9, 5'd1, 5'd2, 32'd8,          32'h0020_8463, 1'b0};
        vecs[2]  = '{6'(OpJal),   5'd1, 5'd3, 5'd4, 32'd2048,       32'h0010_00EF, 1'b0};
        vecs[3]  = '{6'(OpSw),    5'd5, 5'd1, 5'd2, 32'd4,          32'h0020_A223, 1'b0};
        vecs[4]  = '{6'(OpLui),   5'd5, 5'd1, 5'd2, 32'h1234_5000,  32'h1234_52B7, 1'b0};
        vecs[5]  = '{6'(OpAddi),  5'd1, 5'd0, 5'd0, 32'd2048,       32'h0000_0013, 1'b1};
        vecs[6]  = '{6'(OpBeq),   5'd0, 5'd1, 5'd2, 32'd3,          32'h0000_0013, 1'b1};
        vecs[7]  = '{6'(OpSrai),  5'd1, 5'd2, 5'd9, 32'd3,          32'h4031_5093, 1'b0};
        vecs[8]  = '{6'(OpJalr),  5'd1, 5'd2, 5'd9, 32'hFFFF_FFFC,  32'hFFC1_00E7, 1'b0};
        vecs[9]  = '{6'(OpLw),    5'd5, 5'd6, 5'd1, 32'hFFFF_FFFF,  32'hFFF3_2283, 1'b0};
        vecs[10] = '{6'(OpBne),   5'd3, 5'd1, 5'd2, 32'hFFFF_FFFE,  32'hFE20_9FE3, 1'b0};
        vecs[11] = '{6'(OpAddi),  5'd1, 5'd0, 5'd0, 32'hFFFF_F800,  32'h8000_0093, 1'b0};
        vecs[12] = '{6'(OpSlli),  5'd1, 5'd2, 5'd0, 32'd32,         32'h0000_0013, 1'b1};
        vecs[13] = '{6'(OpLui),   5'd5, 5'd0, 5'd0, 32'h1234_5001,  32'h0000_0013, 1'b1};
        vecs[14] = '{6'd63,       5'd1, 5'd1, 5'd1, 32'd0,          32'h0000_0013, 1'b1};
        vecs[15] = '{6'(OpJal),   5'd1, 5'd0, 5'd0, 32'h0010_0000,  32'h0000_0013, 1'b1};

        in_valid  = 1'b0;
        drive(6'(OpAdd), 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back ADD/SUB, also checking address wrap on dut_w.
        drive(6'(OpAdd), 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_inst", out_inst, 32'h0020_81B3);
        chk("add_addr", out_addr, 32'd0);
        chk("wrap_addr0", w_out_addr, 32'hFFFF_FFFC);
        drive(6'(OpSub), 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_inst", out_inst, 32'h4020_81B3);
        chk("sub_addr", out_addr, 32'd4);
        chk("wrap_addr1", w_out_addr, 32'h0000_0000);
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        exp_addr = 32'd8;
        exp_errs = 8'd0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            if (vecs[i].err) exp_errs++;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_inst", i), out_inst, vecs[i].inst);
            chk($sformatf("v%0d_err", i), 32'(out_err), 32'(vecs[i].err));
            chk($sformatf("v%0d_addr", i), out_addr, exp_addr);
            chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(exp_errs));
            exp_addr += 32'd4;
            tick();
            chk($sformatf("v%0d_popped", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: two accepted, third held off, then drain in order.
        out_ready = 1'b0;
        drive(6'(OpAdd), 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        drive(6'(OpXor), 5'd4, 5'd5, 5'd6, 32'd0);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        tick();
        drive(6'(OpAnd), 5'd7, 5'd8, 5'd9, 32'd0);
        chk("bp_full", 32'(in_ready), 32'd0);
        chk("bp_hold_inst0", out_inst, 32'h0031_00B3);
        tick();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold_inst1", out_inst, 32'h0031_00B3);
        chk("bp_hold_addr", out_addr, exp_addr);
        out_ready = 1'b1;
        tick();
        chk("bp_d1_inst", out_inst, 32'h0062_C233);
        chk("bp_d1_addr", out_addr, exp_addr + 32'd4);
        tick();
        in_valid = 1'b0;
        chk("bp_d2_inst", out_inst, 32'h0094_73B3);
        chk("bp_d2_addr", out_addr, exp_addr + 32'd8);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Reset with two words buffered.
        out_ready = 1'b0;
        drive(6'd63, 5'd0, 5'd0, 5'd0, 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        chk("mid_full", 32'(in_ready), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        chk("mid_rst_out_addr", out_addr, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        drive(6'(OpAddi), 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        chk("mid_post_inst", out_inst, 32'h0050_0093);
        chk("mid_post_addr", out_addr, 32'd0);
        chk("mid_post_wrap_addr", w_out_addr, 32'hFFFF_FFFC);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
